// File: rtl/ext_mem_if.sv
// rtl/ext_mem_if.sv - split request / write-data / response bus between harness and memory model
interface ext_mem_if #(
  parameter int DATA_BITS = 128,
  parameter int ADDR_BITS = 28,
  parameter int TAG_BITS  = 5
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_rw;
  logic [ADDR_BITS-1:0]   req_addr;
  logic [TAG_BITS-1:0]    req_tag;
  logic                   req_data_valid;
  logic                   req_data_ready;
  logic [DATA_BITS-1:0]   req_data_bits;
  logic [DATA_BITS/8-1:0] req_data_mask;
  logic                   resp_valid;
  logic [TAG_BITS-1:0]    resp_tag;
  logic [DATA_BITS-1:0]   resp_data;

  modport master (
    output req_valid, req_rw, req_addr, req_tag,
    output req_data_valid, req_data_bits, req_data_mask,
    input  req_ready, req_data_ready, resp_valid, resp_tag, resp_data
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_tag,
    input  req_data_valid, req_data_bits, req_data_mask,
    output req_ready, req_data_ready, resp_valid, resp_tag, resp_data
  );
endinterface

// File: rtl/ext_mem_latency_model.sv
// rtl/ext_mem_latency_model.sv - behavioural external memory with fixed read latency and in-order read queue
// Optional random ready stalls: define MEM_RAND_STALL_EN.
module ext_mem_latency_model #(
  parameter int          DATA_BITS   = 128,
  parameter int          ADDR_BITS   = 28,
  parameter int          TAG_BITS    = 5,
  parameter int          DEPTH_LOG2  = 16,
  parameter int          LATENCY     = 4,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] SEED        = 32'h1
) (
  input  logic     clk,
  input  logic     reset,
  ext_mem_if.slave bus,
  output logic     oob_err
);
  localparam int NBYTES = DATA_BITS / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int TW     = $clog2(LATENCY + 1);
  localparam int PW     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW     = $clog2(QUEUE_DEPTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WDATA = 1'b1;

  localparam logic [TW-1:0] TIMER_INIT = TW'(LATENCY);
  localparam logic [TW-1:0] TIMER_DUE  = TW'(1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(QUEUE_DEPTH);

  logic [DATA_BITS-1:0]  mem [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] waddr_q;
  logic [TAG_BITS-1:0]   qtag_q   [QUEUE_DEPTH];
  logic [DATA_BITS-1:0]  qdata_q  [QUEUE_DEPTH];
  logic [TW-1:0]         qtimer_q [QUEUE_DEPTH];
  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  resp_valid_q;
  logic [TAG_BITS-1:0]   resp_tag_q;
  logic [DATA_BITS-1:0]  resp_data_q;
  logic                  oob_err_q;

  logic                  req_stall, data_stall;
  logic                  req_fire, wdata_fire, push, pop;
  logic [DATA_BITS-1:0]  rd_data;

`ifdef MEM_RAND_STALL_EN
  localparam logic [15:0] LFSR_SEED = (SEED[15:0] == 16'h0) ? 16'h1 : SEED[15:0];
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign req_stall  = (lfsr_q[1:0] == 2'b00);
  assign data_stall = (lfsr_q[3:2] == 2'b00);
`else
  assign req_stall  = 1'b0;
  assign data_stall = 1'b0;
`endif

  assign bus.req_ready      = reset && (state_q == IDLE) && (count_q < COUNT_FULL) && !req_stall;
  assign bus.req_data_ready = reset && (state_q == WDATA) && !data_stall;

  assign req_fire   = bus.req_valid && bus.req_ready;
  assign wdata_fire = bus.req_data_valid && bus.req_data_ready;
  assign push       = req_fire && !bus.req_rw;
  assign pop        = (qtimer_q[head_q] == TIMER_DUE);
  assign rd_data    = mem[bus.req_addr[DEPTH_LOG2-1:0]];

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && req_fire && bus.req_rw) state_d = WDATA;
    if (state_q == WDATA && wdata_fire)            state_d = IDLE;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (req_fire && bus.req_rw) waddr_q <= bus.req_addr[DEPTH_LOG2-1:0];
  end

  // Contents deliberately survive reset so a preloaded image is kept.
  always_ff @(posedge clk) begin
    if (wdata_fire) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.req_data_mask[b]) mem[waddr_q][8*b +: 8] <= bus.req_data_bits[8*b +: 8];
      end
    end
  end

  // A zero timer marks an empty slot; the head reaching one is due this edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) qtimer_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push) tail_q <= (tail_q == PTR_LAST) ? '0 : tail_q + PW'(1);
      if (pop)  head_q <= (head_q == PTR_LAST) ? '0 : head_q + PW'(1);
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (push && PW'(i) == tail_q) qtimer_q[i] <= TIMER_INIT;
        else if (qtimer_q[i] != '0)   qtimer_q[i] <= qtimer_q[i] - TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qtag_q[tail_q]  <= bus.req_tag;
      qdata_q[tail_q] <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
      oob_err_q    <= 1'b0;
    end else begin
      resp_valid_q <= pop;
      if (pop) begin
        resp_tag_q  <= qtag_q[head_q];
        resp_data_q <= qdata_q[head_q];
      end
      if (req_fire && ((bus.req_addr >> DEPTH_LOG2) != '0)) oob_err_q <= 1'b1;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_tag   = resp_tag_q;
  assign bus.resp_data  = resp_data_q;
  assign oob_err        = oob_err_q;
endmodule

// File: tb/tb_ext_mem_latency_model.sv
// tb/tb_ext_mem_latency_model.sv - directed self-checking bench for ext_mem_latency_model
module tb_ext_mem_latency_model;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic oob_err;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    int          at;
    logic [4:0]  tag;
    logic [127:0] data;
  } resp_t;
  resp_t resps[$];

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2 = 128'h00112233_44556677_8899AABB_FFFFFFFF;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;
  localparam logic [127:0] D4 = 128'h11111111_22222222_33333333_44444444;

  ext_mem_if #(.DATA_BITS(128), .ADDR_BITS(28), .TAG_BITS(5)) bus ();

  ext_mem_latency_model #(
    .DATA_BITS(128), .ADDR_BITS(28), .TAG_BITS(5), .DEPTH_LOG2(16),
    .LATENCY(4), .QUEUE_DEPTH(4), .SEED(32'h1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .oob_err(oob_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.resp_valid) resps.push_back('{at: cyc, tag: bus.resp_tag, data: bus.resp_data});
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic rw, input logic [27:0] addr, input logic [4:0] tag,
                        output int acc);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_tag   = tag;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check_val("req_accept", {127'b0, bus.req_ready}, 128'd1);
    acc = cyc + 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [27:0] addr, input logic [127:0] data,
                          input logic [15:0] mask, input int delay);
    int acc;
    int n = 0;
    do_req(1'b1, addr, 5'd0, acc);
    repeat (delay) begin
      check_val("wait_req_ready", {127'b0, bus.req_ready}, 128'd0);
      check_val("wait_data_ready", {127'b0, bus.req_data_ready}, 128'd1);
      @(negedge clk);
    end
    bus.req_data_valid = 1'b1;
    bus.req_data_bits  = data;
    bus.req_data_mask  = mask;
    while (!bus.req_data_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_data_ready) check_val("data_accept", {127'b0, bus.req_data_ready}, 128'd1);
    @(negedge clk);
    bus.req_data_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [27:0] addr, input logic [4:0] tag,
                            input logic [127:0] exp);
    int acc;
    resps.delete();
    do_req(1'b0, addr, tag, acc);
    repeat (6) @(negedge clk);
    check_val({name, "_count"}, 128'(resps.size()), 128'd1);
    if (resps.size() == 1) begin
      check_val({name, "_edge"}, 128'(resps[0].at), 128'(acc + 4));
      check_val({name, "_tag"}, 128'(resps[0].tag), 128'(tag));
      check_val({name, "_data"}, resps[0].data, exp);
    end
    resps.delete();
  endtask

  initial begin
    int acc[6];
    int exp_acc[6];
    int exp_rsp[6];
    bus.req_valid      = 1'b0;
    bus.req_rw         = 1'b0;
    bus.req_addr       = '0;
    bus.req_tag        = '0;
    bus.req_data_valid = 1'b0;
    bus.req_data_bits  = '0;
    bus.req_data_mask  = '0;

    repeat (3) @(negedge clk);
    check_val("rst_resp_valid", {127'b0, bus.resp_valid}, 128'd0);
    check_val("rst_resp_tag", 128'(bus.resp_tag), 128'd0);
    check_val("rst_resp_data", bus.resp_data, 128'd0);
    check_val("rst_oob", {127'b0, oob_err}, 128'd0);
    check_val("rst_data_ready", {127'b0, bus.req_data_ready}, 128'd0);
    check_val("rst_req_ready", {127'b0, bus.req_ready}, 128'd0);
    reset = 1'b1;
    @(negedge clk);
    check_val("idle_req_ready", {127'b0, bus.req_ready}, 128'd1);

    // full write then read back
    do_write(28'h10, D1, 16'hFFFF, 0);
    read_check("t1", 28'h10, 5'd5, D1);

    // partial write touches bytes 0..3 only
    do_write(28'h10, {128{1'b1}}, 16'h000F, 0);
    read_check("t2", 28'h10, 5'd9, D2);

    // six back-to-back reads against a four-deep queue
    resps.delete();
    for (int i = 0; i < 6; i++) do_req(1'b0, 28'h10, 5'(i), acc[i]);
    exp_acc = '{0, 1, 2, 3, 5, 6};
    exp_rsp = '{4, 5, 6, 7, 9, 10};
    for (int i = 1; i < 6; i++) check_val($sformatf("t3_acc%0d", i), 128'(acc[i] - acc[0]), 128'(exp_acc[i]));
    repeat (14) @(negedge clk);
    check_val("t3_count", 128'(resps.size()), 128'd6);
    if (resps.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check_val($sformatf("t3_rsp%0d_edge", i), 128'(resps[i].at - acc[0]), 128'(exp_rsp[i]));
        check_val($sformatf("t3_rsp%0d_tag", i), 128'(resps[i].tag), 128'(i));
      end
      check_val("t3_rsp5_data", resps[5].data, D2);
    end
    resps.delete();

    // delayed write data; stray data in idle is ignored
    do_write(28'h30, D4, 16'hFFFF, 0);
    do_write(28'h30, D3, 16'hFFFF, 3);
    bus.req_data_valid = 1'b1;
    bus.req_data_bits  = D4;
    bus.req_data_mask  = 16'hFFFF;
    @(negedge clk);
    check_val("idle_data_ready", {127'b0, bus.req_data_ready}, 128'd0);
    @(negedge clk);
    bus.req_data_valid = 1'b0;
    read_check("t4", 28'h30, 5'd3, D3);

    // reset with two reads in flight
    resps.delete();
    do_req(1'b0, 28'h10, 5'd1, acc[0]);
    do_req(1'b0, 28'h30, 5'd2, acc[1]);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("t5_req_ready", {127'b0, bus.req_ready}, 128'd1);
    repeat (8) @(negedge clk);
    check_val("t5_no_resp", 128'(resps.size()), 128'd0);
    read_check("t5_keep", 28'h10, 5'd4, D2);

    // out-of-range address wraps and raises the sticky flag
    check_val("t6_oob_before", {127'b0, oob_err}, 128'd0);
    read_check("t6", 28'h0010010, 5'd7, D2);
    check_val("t6_oob_set", {127'b0, oob_err}, 128'd1);
    read_check("t6_after", 28'h30, 5'd8, D3);
    check_val("t6_oob_sticky", {127'b0, oob_err}, 128'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("t6_oob_cleared", {127'b0, oob_err}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
